// File: rtl/audio_udp_packetizer.sv
// Audio sample FIFO feeding a UDP word stream, two samples per word.
// Optional per-packet sequence header word under AUDIO_PKT_SEQ_HDR_EN.
module audio_udp_packetizer #(
  parameter int PKT_SAMPLES = 256,
  parameter int FIFO_DEPTH  = 1024,
  parameter int AW          = 10
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          audio_en,
  input  logic [15:0]   audio_data,
  output logic          tx_start_en,
  output logic [15:0]   tx_byte_num,
  input  logic          tx_req,
  output logic [31:0]   tx_data,
  input  logic          tx_done,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   ovf_cnt,
  output logic [15:0]   pkt_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

`ifdef AUDIO_PKT_SEQ_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  localparam int          WT      = PKT_SAMPLES / 2 + HDR;
  localparam logic [15:0] LAST    = 16'(WT - 1);
  localparam logic [15:0] BYTES   = 16'(2 * PKT_SAMPLES + 4 * HDR);
  localparam logic [AW:0] DEPTH   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] PKT_LVL = (AW + 1)'(PKT_SAMPLES);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [1:0]    state;
  logic [15:0]   word_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [15:0]   rd_a;
  logic [15:0]   rd_b;
  logic          issue;
  logic          hdr_slot;
  logic          pop;
  logic          wr;

  assign issue = (state == S_SEND) && tx_req;
`ifdef AUDIO_PKT_SEQ_HDR_EN
  assign hdr_slot = (word_cnt == 16'd0);
`else
  assign hdr_slot = 1'b0;
`endif
  assign pop    = issue && !hdr_slot;
  assign wr     = audio_en && (fifo_level != DEPTH);
  assign rd_nxt = pop ? rd_ptr + AW'(2) : rd_ptr;

  // Read address looks one pop ahead so rd_a/rd_b always hold the head pair.
  always_ff @(posedge sys_clk) begin
    if (wr) mem[wr_ptr] <= audio_data;
    rd_a <= mem[rd_nxt];
    rd_b <= mem[rd_nxt + AW'(1)];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ovf_cnt     <= '0;
      pkt_cnt     <= '0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      tx_data     <= '0;
    end else begin
      tx_start_en <= 1'b0;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(2);
      fifo_level <= fifo_level + (AW + 1)'(wr)
                    - (pop ? (AW + 1)'(2) : '0);
      if (audio_en && !wr && ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
      unique case (state)
        S_IDLE: begin
          if (fifo_level >= PKT_LVL) begin
            state       <= S_START;
            tx_start_en <= 1'b1;
            tx_byte_num <= BYTES;
            word_cnt    <= '0;
          end
        end
        S_START: state <= S_SEND;
        S_SEND: begin
          if (tx_req) begin
            tx_data  <= hdr_slot ? {16'hA55A, pkt_cnt} : {rd_a, rd_b};
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt == LAST) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_udp_packetizer.sv
// Directed bench for audio_udp_packetizer, PKT_SAMPLES=4, FIFO_DEPTH=8.
// Expectations follow AUDIO_PKT_SEQ_HDR_EN when defined.
module tb_audio_udp_packetizer;

`ifdef AUDIO_PKT_SEQ_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam logic [15:0] EXP_BYTES = HDR ? 16'd12 : 16'd8;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        audio_en = 1'b0;
  logic [15:0] audio_data = '0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req = 1'b0;
  logic [31:0] tx_data;
  logic        tx_done = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] ovf_cnt;
  logic [15:0] pkt_cnt;

  int checks = 0;
  int failures = 0;
  int starts = 0;

  audio_udp_packetizer #(
    .PKT_SAMPLES(4),
    .FIFO_DEPTH (8),
    .AW         (3)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .audio_en   (audio_en),
    .audio_data (audio_data),
    .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk)
    if (rst_n && tx_start_en) starts++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] d);
    audio_en = 1'b1;
    audio_data = d;
    @(negedge sys_clk);
    audio_en = 1'b0;
  endtask

  task automatic req(input bit w, input logic [15:0] d);
    tx_req = 1'b1;
    audio_en = w;
    audio_data = d;
    @(negedge sys_clk);
    tx_req = 1'b0;
    audio_en = 1'b0;
  endtask

  task automatic done();
    tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge sys_clk);
      seen = tx_start_en;
    end
    chk(tag, 32'(seen), 32'd1);
    @(negedge sys_clk);
  endtask

  task automatic hdr_word(input string tag, input logic [15:0] pc);
    if (HDR) begin
      req(1'b0, 16'h0);
      chk(tag, tx_data, {16'hA55A, pc});
    end
  endtask

  task automatic rd_pkt(input string tag, input logic [15:0] base,
                        input logic [15:0] pc);
    hdr_word({tag, "_hdr"}, pc);
    for (int i = 0; i < 2; i++) begin
      req(1'b0, 16'h0);
      chk(tag, tx_data, {base + 16'(2 * i), base + 16'(2 * i + 1)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int rs;
    int s0;
    logic [15:0] pc;

    idle(2);
    chk("rst_start", 32'(tx_start_en), 32'd0);
    chk("rst_bytes", 32'(tx_byte_num), 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic packet
    for (int i = 1; i <= 4; i++) wr(16'(i));
    wait_start("t1_start");
    chk("t1_bytes", 32'(tx_byte_num), 32'(EXP_BYTES));
    chk("t1_nstart", starts, 1);
    rd_pkt("t1_word", 16'h0001, 16'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);
    req(1'b0, 16'h0);
    chk("t6_req_wait", tx_data, 32'h00030004);
    done();
    chk("t1_pkt", 32'(pkt_cnt), 32'd1);
    chk("t1_bytes_hold", 32'(tx_byte_num), 32'(EXP_BYTES));
    done();
    chk("t6_done_idle", 32'(pkt_cnt), 32'd1);
    req(1'b0, 16'h0);
    chk("t6_req_idle", tx_data, 32'h00030004);
    chk("t6_level", 32'(fifo_level), 32'd0);

    // Overflow: 10 writes into 8 entries
    for (int i = 0; i < 10; i++) wr(16'(16'h0010 + i));
    idle(3);
    chk("t2_level", 32'(fifo_level), 32'd8);
    chk("t2_ovf", 32'(ovf_cnt), 32'd2);
    chk("t2_nstart", starts, 2);
    rd_pkt("t2_w0", 16'h0010, 16'd1);
    done();
    wait_start("t2_start2");
    rd_pkt("t2_w1", 16'h0014, 16'd2);
    done();
    chk("t2_pkt", 32'(pkt_cnt), 32'd3);
    chk("t2_level_end", 32'(fifo_level), 32'd0);

    // Writes coincident with every tx_req over 4 packets
    for (int i = 0; i < 4; i++) wr(16'(16'h0100 + i));
    nw = 4;
    rs = 0;
    for (int p = 0; p < 4; p++) begin
      wait_start("t3_start");
      pc = 16'(3 + p);
      if (HDR) begin
        req(nw < 16, 16'(16'h0100 + nw));
        if (nw < 16) nw++;
        chk("t3_hdr", tx_data, {16'hA55A, pc});
      end
      for (int k = 0; k < 2; k++) begin
        req(nw < 16, 16'(16'h0100 + nw));
        if (nw < 16) nw++;
        chk("t3_word", tx_data,
            {16'(16'h0100 + rs), 16'(16'h0100 + rs + 1)});
        rs += 2;
      end
      done();
      while (nw < 16 && nw < 4 * (p + 2)) begin
        wr(16'(16'h0100 + nw));
        nw++;
      end
    end
    chk("t3_level", 32'(fifo_level), 32'd0);
    chk("t3_ovf", 32'(ovf_cnt), 32'd2);
    chk("t3_pkt", 32'(pkt_cnt), 32'd7);

    // Asynchronous reset in the middle of a packet
    for (int i = 0; i < 4; i++) wr(16'(16'h0200 + i));
    wait_start("t4_start");
    hdr_word("t4_hdr", 16'd7);
    req(1'b0, 16'h0);
    chk("t4_w0", tx_data, 32'h02000201);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_data", tx_data, 32'd0);
    chk("t4_rst_bytes", 32'(tx_byte_num), 32'd0);
    chk("t4_rst_level", 32'(fifo_level), 32'd0);
    chk("t4_rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("t4_rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("t4_rst_start", 32'(tx_start_en), 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    s0 = starts;
    for (int i = 0; i < 3; i++) wr(16'(16'h0300 + i));
    idle(4);
    chk("t4_nostart", starts, s0);
    chk("t4_level3", 32'(fifo_level), 32'd3);
    wr(16'h0303);
    wait_start("t4_start2");
    rd_pkt("t4_word", 16'h0300, 16'd0);
    done();
    chk("t4_pkt", 32'(pkt_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
